scratchpad_arbiter_2p: RTL and testbench
========================================

// Module: scratchpad_arbiter_2p
// PURPOSE
//  Two-port Avalon-MM arbiter that shares one single-port 4096x32 scratchpad RAM between the processor data master (port 0) and the fingerprint/DMA master (port 1).
//  Issues at most one RAM access per cycle.
//  Returns read data with the RAM's fixed 1-cycle latency, tagged to the issuing port.
//  Supports locked sequences (arbiterlock) so one master can own the RAM for back-to-back accesses.
// PARAMETERS
//  ADDR_W        12  word address width (4096 words)
//  DATA_W        32  data width
//  BE_W          4   byteenable width (DATA_W/8)
//  LOCK_TIMEOUT  16  idle cycles after which a held lock is forcibly released (>=1)
// PORTS
//  clk               in   1       system clock
//  reset             in   1       asynchronous, active-high reset
//  sN_address        in   ADDR_W  port N word address (N=0,1)
//  sN_byteenable     in   BE_W    port N byte enables (writes only)
//  sN_read           in   1       port N read request
//  sN_write          in   1       port N write request
//  sN_writedata      in   DATA_W  port N write data
//  sN_lock           in   1       port N requests the grant be held after this access
//  sN_waitrequest    out  1       port N stall; request accepted in a cycle where it is 0
//  sN_readdata       out  DATA_W  port N read data
//  sN_readdatavalid  out  1       port N read data valid, 1 cycle after read accept
//  m_address         out  ADDR_W  to RAM address
//  m_byteenable      out  BE_W    to RAM byteenable; 4'hF on reads
//  m_chipselect      out  1       to RAM chipselect
//  m_write           out  1       to RAM write
//  m_writedata       out  DATA_W  to RAM data
//  m_clken           out  1       to RAM clock enable; constant 1
//  m_readdata        in   DATA_W  from RAM q (valid 1 cycle after a read is issued)
// BEHAVIOUR
//  - reqN = sN_read | sN_write. Read and write asserted together on one port is illegal; write wins.
//  - Grant is combinational from reqN, the FSM state and last_grant.
//  - Grant rules:
//    - m_chipselect = req of the granted port; m_* mux from the granted port.
//    - sN_waitrequest = reset | (reqN & ~grantN).
//    - With no request, sN_waitrequest = 0 outside reset.
//  - FSM states:
//    - IDLE: arbitrate between the two ports. A granted access with sN_lock=1 -> LOCKN. Otherwise stay in IDLE.
//    - LOCKN: only port N may be granted.
//      - Exit to IDLE on a granted port N access with sN_lock=0; that access completes.
//      - Exit to IDLE when idle_cnt reaches LOCK_TIMEOUT.
//      - idle_cnt clears on each port N access and counts cycles with reqN=0.
//  - Round-robin (IDLE, both requesting): grant the port != last_grant. last_grant updates on every granted access.
//  - Read return:
//    - rd_pend[1:0] (one-hot) is registered when a read is issued.
//    - sN_readdatavalid = rd_pend[N] (1 cycle latency).
//    - sN_readdata = m_readdata for both ports.
//    - Back-to-back reads from alternating ports return in issue order, one per cycle.
//  - Write-then-read of the same address on consecutive cycles returns the new data (RAM is single-port, in order).
//  - Reset values:
//    - state=IDLE, last_grant=1 (port 0 wins the first contention), idle_cnt=0, rd_pend=0.
//    - readdatavalid=0, waitrequest=1 while reset is high, m_chipselect=0.
//  - Reset mid-operation: a pending readdatavalid is dropped; a held lock is cleared.
// CONFIGURATION
//  - SPAD_ARB_FIXED_PRIO_EN defined:
//    - In IDLE, port 0 always wins contention; last_grant is unused.
//    - Locks still apply.
//  - SPAD_ARB_FIXED_PRIO_EN undefined:
//    - Round-robin as above.
// TESTING
//  - Reset then single access: port 0 writes 0xDEADBEEF @0x010 with BE=4'hF, then reads 0x010.
//    -> s0_readdatavalid=1 exactly 1 cycle after read accept, s0_readdata=0xDEADBEEF.
//  - Contention: both ports read continuously for 8 cycles.
//    -> grants alternate 0,1,0,1,...; each port gets 4 readdatavalid pulses with no cross-delivery.
//    -> With SPAD_ARB_FIXED_PRIO_EN: port 0 gets all 8 and s1_waitrequest stays 1.
//  - Byte write: port 1 writes 0x11223344 @0x0FF with BE=4'b0101 over prior 0xAAAAAAAA, then reads.
//    -> 0xAA22AA44.
//  - Lock: port 1 issues 3 writes with lock=1 then one with lock=0, while port 0 requests throughout.
//    -> port 0 is stalled all 4 cycles and granted on the 5th.
//  - Lock timeout (LOCK_TIMEOUT=16): port 0 locks, then goes idle while port 1 requests.
//    -> port 1 is granted exactly 16 idle cycles later.
//  - Reset asserted the cycle after a port 1 read is issued.
//    -> no s1_readdatavalid pulse; both waitrequest=1 during reset; the next contention after release grants port 0.

Source files
------------

// File: rtl/scratchpad_arbiter_2p_if.sv
`default_nettype none
// ============================================================================
// Module      : scratchpad_arbiter_2p_if
// Description : Bus bundle for the two-port scratchpad arbiter: two
//               Avalon-MM slave ports (s0_*, s1_*) and the RAM-side
//               master port (m_*).
// Revision    : 1.0 - initial release
// ============================================================================
interface scratchpad_arbiter_2p_if #(
   parameter int ADDR_W = 12,
   parameter int DATA_W = 32,
   parameter int BE_W   = 4
);
   // port 0: processor data master
   logic [ADDR_W-1:0] s0_address;
   logic [BE_W-1:0]   s0_byteenable;
   logic              s0_read;
   logic              s0_write;
   logic [DATA_W-1:0] s0_writedata;
   logic              s0_lock;
   logic              s0_waitrequest;
   logic [DATA_W-1:0] s0_readdata;
   logic              s0_readdatavalid;
   // port 1: fingerprint/DMA master
   logic [ADDR_W-1:0] s1_address;
   logic [BE_W-1:0]   s1_byteenable;
   logic              s1_read;
   logic              s1_write;
   logic [DATA_W-1:0] s1_writedata;
   logic              s1_lock;
   logic              s1_waitrequest;
   logic [DATA_W-1:0] s1_readdata;
   logic              s1_readdatavalid;
   // RAM side
   logic [ADDR_W-1:0] m_address;
   logic [BE_W-1:0]   m_byteenable;
   logic              m_chipselect;
   logic              m_write;
   logic [DATA_W-1:0] m_writedata;
   logic              m_clken;
   logic [DATA_W-1:0] m_readdata;

   // arbiter view
   modport slave (
      input  s0_address, s0_byteenable, s0_read, s0_write, s0_writedata, s0_lock,
      output s0_waitrequest, s0_readdata, s0_readdatavalid,
      input  s1_address, s1_byteenable, s1_read, s1_write, s1_writedata, s1_lock,
      output s1_waitrequest, s1_readdata, s1_readdatavalid,
      output m_address, m_byteenable, m_chipselect, m_write, m_writedata, m_clken,
      input  m_readdata
   );

   // environment view: requesting masters plus the RAM
   modport master (
      output s0_address, s0_byteenable, s0_read, s0_write, s0_writedata, s0_lock,
      input  s0_waitrequest, s0_readdata, s0_readdatavalid,
      output s1_address, s1_byteenable, s1_read, s1_write, s1_writedata, s1_lock,
      input  s1_waitrequest, s1_readdata, s1_readdatavalid,
      input  m_address, m_byteenable, m_chipselect, m_write, m_writedata, m_clken,
      output m_readdata
   );
endinterface
`default_nettype wire

// File: rtl/scratchpad_arbiter_2p.sv
`default_nettype none
// ============================================================================
// Module      : scratchpad_arbiter_2p
// Description : Shares one single-port 4096x32 scratchpad RAM between two
//               Avalon-MM masters. One RAM access per cycle, read data
//               returned with the RAM's 1-cycle latency to the issuing port,
//               locked sequences with an idle timeout.
//               Optional macro SPAD_ARB_FIXED_PRIO_EN: port 0 always wins
//               contention in IDLE instead of round-robin.
// Revision    : 1.0 - initial release
// ============================================================================
module scratchpad_arbiter_2p #(
   parameter int ADDR_W       = 12,
   parameter int DATA_W       = 32,
   parameter int BE_W         = 4,
   parameter int LOCK_TIMEOUT = 16
) (
   input wire                    clk,
   input wire                    reset,
   scratchpad_arbiter_2p_if.slave bus
);

   localparam int            c_cnt_w     = $clog2(LOCK_TIMEOUT + 1);
   localparam logic [c_cnt_w-1:0] c_idle_last = c_cnt_w'(LOCK_TIMEOUT - 1);

   localparam logic [1:0] c_st_idle  = 2'd0;
   localparam logic [1:0] c_st_lock0 = 2'd1;
   localparam logic [1:0] c_st_lock1 = 2'd2;

   logic [1:0]         r_state;
   logic [1:0]         w_next_state;
   logic               r_last_grant;
   logic [c_cnt_w-1:0] r_idle_cnt;
   logic [c_cnt_w-1:0] w_idle_cnt_next;
   logic [1:0]         r_rd_pend;

   logic w_req0, w_req1;
   logic w_grant0, w_grant1;
   logic w_own_req, w_own_grant, w_own_lock;
   logic w_sel_write;

   assign w_req0 = bus.s0_read | bus.s0_write;
   assign w_req1 = bus.s1_read | bus.s1_write;

   // in a lock state, the view of the owning port
   assign w_own_req   = (r_state == c_st_lock1) ? w_req1       : w_req0;
   assign w_own_grant = (r_state == c_st_lock1) ? w_grant1     : w_grant0;
   assign w_own_lock  = (r_state == c_st_lock1) ? bus.s1_lock  : bus.s0_lock;

   // state, lock idle counter and last-grant registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state      <= c_st_idle;
         r_idle_cnt   <= '0;
         r_last_grant <= 1'b1;
      end else begin
         r_state    <= w_next_state;
         r_idle_cnt <= w_idle_cnt_next;
         if (w_grant0)
            r_last_grant <= 1'b0;
         else if (w_grant1)
            r_last_grant <= 1'b1;
      end
   end

   // next state: enter a lock on a locked grant, leave on an unlocked
   // access by the owner or after LOCK_TIMEOUT consecutive idle cycles
   always_comb begin
      w_next_state    = r_state;
      w_idle_cnt_next = r_idle_cnt;
      case (r_state)
         c_st_idle: begin
            w_idle_cnt_next = '0;
            if (w_grant0 && bus.s0_lock)
               w_next_state = c_st_lock0;
            else if (w_grant1 && bus.s1_lock)
               w_next_state = c_st_lock1;
         end
         c_st_lock0, c_st_lock1: begin
            if (w_own_grant) begin
               w_idle_cnt_next = '0;
               if (!w_own_lock)
                  w_next_state = c_st_idle;
            end else if (!w_own_req) begin
               if (r_idle_cnt == c_idle_last) begin
                  w_idle_cnt_next = '0;
                  w_next_state    = c_st_idle;
               end else begin
                  w_idle_cnt_next = r_idle_cnt + 1'b1;
               end
            end
         end
         default: begin
            w_idle_cnt_next = '0;
            w_next_state    = c_st_idle;
         end
      endcase
   end

   // grant decode from requests, state and last grant; nothing while in reset
   always_comb begin
      w_grant0 = 1'b0;
      w_grant1 = 1'b0;
      if (!reset) begin
         case (r_state)
            c_st_idle: begin
               if (w_req0 && w_req1) begin
`ifdef SPAD_ARB_FIXED_PRIO_EN
                  w_grant0 = 1'b1;
`else
                  w_grant0 = r_last_grant;
                  w_grant1 = ~r_last_grant;
`endif
               end else begin
                  w_grant0 = w_req0;
                  w_grant1 = w_req1;
               end
            end
            c_st_lock0: w_grant0 = w_req0;
            c_st_lock1: w_grant1 = w_req1;
            default: ;
         endcase
      end
   end

   // remember which port issued a read so its data valid comes back tagged
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         r_rd_pend <= 2'b00;
      else
         r_rd_pend <= {w_grant1 & bus.s1_read & ~bus.s1_write,
                       w_grant0 & bus.s0_read & ~bus.s0_write};
   end

   // RAM-side mux; write wins when a port drives read and write together
   assign w_sel_write      = w_grant1 ? bus.s1_write : (w_grant0 & bus.s0_write);
   assign bus.m_chipselect = w_grant0 | w_grant1;
   assign bus.m_write      = w_sel_write;
   assign bus.m_address    = w_grant1 ? bus.s1_address   : bus.s0_address;
   assign bus.m_writedata  = w_grant1 ? bus.s1_writedata : bus.s0_writedata;
   assign bus.m_byteenable = !w_sel_write ? {BE_W{1'b1}} :
                             (w_grant1 ? bus.s1_byteenable : bus.s0_byteenable);
   assign bus.m_clken      = 1'b1;

   assign bus.s0_waitrequest   = reset | (w_req0 & ~w_grant0);
   assign bus.s1_waitrequest   = reset | (w_req1 & ~w_grant1);
   assign bus.s0_readdata      = bus.m_readdata;
   assign bus.s1_readdata      = bus.m_readdata;
   assign bus.s0_readdatavalid = r_rd_pend[0];
   assign bus.s1_readdatavalid = r_rd_pend[1];

endmodule
`default_nettype wire

// File: tb/tb_scratchpad_arbiter_2p.sv
`default_nettype none
// ============================================================================
// Module      : tb_scratchpad_arbiter_2p
// Description : Directed bench for scratchpad_arbiter_2p with a behavioural
//               1-cycle RAM. Stimulus pushes expected stalls and read data
//               into queues; a negedge monitor pops and compares.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_scratchpad_arbiter_2p;

   logic clk;
   logic reset;

   scratchpad_arbiter_2p_if #(.ADDR_W(12), .DATA_W(32), .BE_W(4)) bus ();

   scratchpad_arbiter_2p #(
      .ADDR_W(12), .DATA_W(32), .BE_W(4), .LOCK_TIMEOUT(16)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // behavioural single-port RAM, 1-cycle read latency, byte enables
   logic [31:0] mem [0:4095];
   always @(posedge clk) begin
      if (bus.m_chipselect && bus.m_clken) begin
         if (bus.m_write) begin
            for (int b = 0; b < 4; b++)
               if (bus.m_byteenable[b])
                  mem[bus.m_address][8*b +: 8] <= bus.m_writedata[8*b +: 8];
         end else begin
            bus.m_readdata <= mem[bus.m_address];
         end
      end
   end

   int cyc_n = 0;
   always @(posedge clk) cyc_n <= cyc_n + 1;

   typedef struct packed {
      logic        rd, wr, lk, sb;
      logic [11:0] a;
      logic [3:0]  be;
      logic [31:0] d;
      logic [31:0] x;
   } req_t;

   typedef struct {
      logic  w0, w1;
      string nm;
   } wexp_t;

   typedef struct {
      logic [31:0] d;
      int          due;
   } rexp_t;

   wexp_t wq[$];
   rexp_t rq0[$];
   rexp_t rq1[$];
   logic  done = 1'b0;
   int    checks = 0;
   int    failures = 0;

   function automatic req_t nop();
      return '{default: '0};
   endfunction
   function automatic req_t rd(input logic [11:0] a, input logic [31:0] x, input logic lk);
      req_t r = '{default: '0};
      r.rd = 1'b1; r.lk = lk; r.sb = 1'b1; r.a = a; r.x = x; r.be = 4'hF;
      return r;
   endfunction
   function automatic req_t rdx(input logic [11:0] a);
      req_t r = '{default: '0};
      r.rd = 1'b1; r.a = a; r.be = 4'hF;
      return r;
   endfunction
   function automatic req_t wr(input logic [11:0] a, input logic [3:0] be,
                               input logic [31:0] d, input logic lk);
      req_t r = '{default: '0};
      r.wr = 1'b1; r.lk = lk; r.a = a; r.be = be; r.d = d;
      return r;
   endfunction

   // one bus cycle: drive both ports, register expected stalls and read data
   task automatic cyc(input req_t p0, input req_t p1, input logic e0, input logic e1,
                      input logic rs, input string nm);
      @(posedge clk);
      #1;
      reset = rs;
      bus.s0_read = p0.rd; bus.s0_write = p0.wr; bus.s0_lock = p0.lk;
      bus.s0_address = p0.a; bus.s0_byteenable = p0.be; bus.s0_writedata = p0.d;
      bus.s1_read = p1.rd; bus.s1_write = p1.wr; bus.s1_lock = p1.lk;
      bus.s1_address = p1.a; bus.s1_byteenable = p1.be; bus.s1_writedata = p1.d;
      wq.push_back('{w0: e0, w1: e1, nm: nm});
      if (p0.rd && p0.sb && !e0 && !rs) rq0.push_back('{d: p0.x, due: cyc_n + 1});
      if (p1.rd && p1.sb && !e1 && !rs) rq1.push_back('{d: p1.x, due: cyc_n + 1});
   endtask

   function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc_n);
      end
   endfunction

   // monitor / scoreboard
   always @(negedge clk) begin
      wexp_t w;
      rexp_t r;
      if (wq.size() > 0) begin
         w = wq.pop_front();
         chk({w.nm, " s0_waitrequest"}, {31'd0, bus.s0_waitrequest}, {31'd0, w.w0});
         chk({w.nm, " s1_waitrequest"}, {31'd0, bus.s1_waitrequest}, {31'd0, w.w1});
      end
      if (bus.s0_readdatavalid) begin
         if (rq0.size() == 0) chk("s0 unexpected readdatavalid", 32'd1, 32'd0);
         else begin
            r = rq0.pop_front();
            chk("s0 readdata", bus.s0_readdata, r.d);
            chk("s0 read latency cycle", cyc_n, r.due);
         end
      end else if (rq0.size() > 0 && rq0[0].due <= cyc_n) begin
         r = rq0.pop_front();
         chk("s0 missing readdatavalid", 32'd0, 32'd1);
      end
      if (bus.s1_readdatavalid) begin
         if (rq1.size() == 0) chk("s1 unexpected readdatavalid", 32'd1, 32'd0);
         else begin
            r = rq1.pop_front();
            chk("s1 readdata", bus.s1_readdata, r.d);
            chk("s1 read latency cycle", cyc_n, r.due);
         end
      end else if (rq1.size() > 0 && rq1[0].due <= cyc_n) begin
         r = rq1.pop_front();
         chk("s1 missing readdatavalid", 32'd0, 32'd1);
      end
      if (done && wq.size() == 0) begin
         chk("s0 scoreboard drained", rq0.size(), 32'd0);
         chk("s1 scoreboard drained", rq1.size(), 32'd0);
         $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
         $finish;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   // directed stimulus
   initial begin
      reset = 1'b1;
      bus.s0_read = 0; bus.s0_write = 0; bus.s0_lock = 0;
      bus.s0_address = '0; bus.s0_byteenable = '0; bus.s0_writedata = '0;
      bus.s1_read = 0; bus.s1_write = 0; bus.s1_lock = 0;
      bus.s1_address = '0; bus.s1_byteenable = '0; bus.s1_writedata = '0;

      cyc(nop(), nop(), 1, 1, 1, "reset idle");
      cyc(rd(12'h010, 0, 0), rd(12'h010, 0, 0), 1, 1, 1, "reset req");

      // single write then read of the same word
      cyc(wr(12'h010, 4'hF, 32'hDEADBEEF, 0), nop(), 0, 0, 0, "p0 write");
      cyc(rd(12'h010, 32'hDEADBEEF, 0), nop(), 0, 0, 0, "p0 read");
      cyc(nop(), nop(), 0, 0, 0, "idle");

      // byte-enable write from port 1
      cyc(nop(), wr(12'h0FF, 4'hF, 32'hAAAAAAAA, 0), 0, 0, 0, "p1 fill");
      cyc(nop(), wr(12'h0FF, 4'b0101, 32'h11223344, 0), 0, 0, 0, "p1 byte write");
      cyc(nop(), rd(12'h0FF, 32'hAA22AA44, 0), 0, 0, 0, "p1 read");
      cyc(nop(), nop(), 0, 0, 0, "idle");

      // contention: both read for 8 cycles, last grant was port 1
      for (int i = 0; i < 8; i++) begin
`ifdef SPAD_ARB_FIXED_PRIO_EN
         cyc(rd(12'h010, 32'hDEADBEEF, 0), rd(12'h0FF, 32'hAA22AA44, 0), 0, 1, 0, "contend");
`else
         cyc(rd(12'h010, 32'hDEADBEEF, 0), rd(12'h0FF, 32'hAA22AA44, 0),
             (i % 2) == 1, (i % 2) == 0, 0, "contend");
`endif
      end
      cyc(nop(), nop(), 0, 0, 0, "idle");

      // port 0 access so port 1 wins the next round-robin contention
      cyc(wr(12'h020, 4'hF, 32'h01234567, 0), nop(), 0, 0, 0, "p0 write 020");

      // locked burst from port 1 while port 0 requests
`ifdef SPAD_ARB_FIXED_PRIO_EN
      cyc(nop(), wr(12'h030, 4'hF, 32'hC0DE0000, 1), 0, 0, 0, "lock w0");
`else
      cyc(rd(12'h020, 32'h01234567, 0), wr(12'h030, 4'hF, 32'hC0DE0000, 1), 1, 0, 0, "lock w0");
`endif
      cyc(rd(12'h020, 32'h01234567, 0), wr(12'h031, 4'hF, 32'hC0DE0001, 1), 1, 0, 0, "lock w1");
      cyc(rd(12'h020, 32'h01234567, 0), wr(12'h032, 4'hF, 32'hC0DE0002, 1), 1, 0, 0, "lock w2");
      cyc(rd(12'h020, 32'h01234567, 0), wr(12'h033, 4'hF, 32'hC0DE0003, 0), 1, 0, 0, "lock w3");
      cyc(rd(12'h020, 32'h01234567, 0), nop(), 0, 0, 0, "after unlock");
      cyc(nop(), rd(12'h033, 32'hC0DE0003, 0), 0, 0, 0, "p1 read 033");

      // lock timeout: port 0 locks and goes idle, port 1 waits 16 cycles
      cyc(rd(12'h010, 32'hDEADBEEF, 1), nop(), 0, 0, 0, "p0 lock");
      for (int i = 0; i < 16; i++)
         cyc(nop(), rd(12'h020, 32'h01234567, 0), 0, 1, 0, "lock held");
      cyc(nop(), rd(12'h020, 32'h01234567, 0), 0, 0, 0, "lock timed out");
      cyc(nop(), nop(), 0, 0, 0, "idle");

      // reset the cycle after a port 1 read: its data valid must vanish
      cyc(nop(), rdx(12'h0FF), 0, 0, 0, "p1 read pre-reset");
      cyc(rd(12'h010, 0, 0), rd(12'h0FF, 0, 0), 1, 1, 1, "mid reset a");
      cyc(rd(12'h010, 0, 0), rd(12'h0FF, 0, 0), 1, 1, 1, "mid reset b");
      cyc(rd(12'h010, 32'hDEADBEEF, 0), rd(12'h0FF, 32'hAA22AA44, 0), 0, 1, 0, "post reset contend");
      cyc(nop(), rd(12'h0FF, 32'hAA22AA44, 0), 0, 0, 0, "post reset p1");
      cyc(nop(), nop(), 0, 0, 0, "idle");
      cyc(nop(), nop(), 0, 0, 0, "idle");
      done = 1'b1;
   end

endmodule
`default_nettype wire
